// File: rtl/mest_pro_pkg.sv
// Shared types and constants for the MEST Pro control/decode stage:
// opcode, sequencer state, ALU op and the decoded control bundle.
package mest_pro_pkg;

    localparam int OP_CODE_SIZE     = 4;
    localparam int FIELD_W          = 8;
    localparam int INSTRUCTION_SIZE = OP_CODE_SIZE + 3 * FIELD_W;

    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRCA_LSB = 8;
    localparam int SRCB_LSB = 0;

    typedef enum logic [OP_CODE_SIZE-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDK  = 4'h6,
        OP_MOV  = 4'h7,
        OP_JMP  = 4'h8,
        OP_CALL = 4'h9,
        OP_RET  = 4'hA,
        OP_JZ   = 4'hB,
        OP_HALT = 4'hC
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    imm_sel;
        logic    rf_we;
        logic    jump;
        logic    is_jz;
        logic    ret;
        logic    halt;
        logic    illegal;
    } ctrl_t;

    function automatic logic [FIELD_W-1:0] field_of(input logic [INSTRUCTION_SIZE-1:0] instr,
                                                   input int lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/mest_pro_control_if.sv
// Signal bundle between the control stage, the fetch stage and the datapath.
// Handshake: no valid/ready; i_start is a level sampled only in IDLE, everything else is per-cycle.
interface mest_pro_control_if;
    import mest_pro_pkg::*;

    logic                        i_start;
    logic                        i_stop;
    logic [INSTRUCTION_SIZE-1:0] i_decode_reg;
    logic                        i_zero_flag;
    logic                        o_idle_state;
    logic                        o_fetch_state;
    logic                        o_exec_state;
    logic                        o_jump;
    logic                        o_return_pc;
    logic [FIELD_W-1:0]          o_const_K;
    logic [2:0]                  o_alu_op;
    logic                        o_imm_sel;
    logic                        o_rf_we;
    logic [FIELD_W-1:0]          o_rf_waddr;
    logic [FIELD_W-1:0]          o_rf_raddr_a;
    logic [FIELD_W-1:0]          o_rf_raddr_b;
    logic                        o_busy;
    logic                        o_done;
    logic                        o_illegal;
    state_e                      o_dbg_state;

    modport master (
        output i_start, i_stop, i_decode_reg, i_zero_flag,
        input  o_idle_state, o_fetch_state, o_exec_state, o_jump, o_return_pc,
               o_const_K, o_alu_op, o_imm_sel, o_rf_we, o_rf_waddr,
               o_rf_raddr_a, o_rf_raddr_b, o_busy, o_done, o_illegal, o_dbg_state
    );

    modport slave (
        input  i_start, i_stop, i_decode_reg, i_zero_flag,
        output o_idle_state, o_fetch_state, o_exec_state, o_jump, o_return_pc,
               o_const_K, o_alu_op, o_imm_sel, o_rf_we, o_rf_waddr,
               o_rf_raddr_a, o_rf_raddr_b, o_busy, o_done, o_illegal, o_dbg_state
    );

endinterface

// File: rtl/mest_pro_decoder.sv
// Combinational opcode decoder: maps a registered opcode to the control bundle.
// Reserved opcodes decode as NOP with the illegal flag raised.
module mest_pro_decoder
    import mest_pro_pkg::*;
(
    input  opcode_e i_opcode,
    output ctrl_t   o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_NOP:  ;
            OP_ADD:  begin o_ctrl.alu_op = ALU_ADD; o_ctrl.rf_we = 1'b1; end
            OP_SUB:  begin o_ctrl.alu_op = ALU_SUB; o_ctrl.rf_we = 1'b1; end
            OP_AND:  begin o_ctrl.alu_op = ALU_AND; o_ctrl.rf_we = 1'b1; end
            OP_OR:   begin o_ctrl.alu_op = ALU_OR;  o_ctrl.rf_we = 1'b1; end
            OP_XOR:  begin o_ctrl.alu_op = ALU_XOR; o_ctrl.rf_we = 1'b1; end
            OP_LDK:  begin o_ctrl.imm_sel = 1'b1;   o_ctrl.rf_we = 1'b1; end
            OP_MOV:  o_ctrl.rf_we   = 1'b1;
            OP_JMP:  o_ctrl.jump    = 1'b1;
            OP_CALL: o_ctrl.jump    = 1'b1;
            OP_RET:  o_ctrl.ret     = 1'b1;
            OP_JZ:   o_ctrl.is_jz   = 1'b1;
            OP_HALT: o_ctrl.halt    = 1'b1;
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mest_pro_control.sv
// MEST Pro control stage: IDLE/FETCH/DECODE/EXEC/DONE sequencer, decode registers,
// and EXEC-gated branch / register-write controls. One instruction in flight.
module mest_pro_control
    import mest_pro_pkg::*;
(
    input  logic               clk,
    input  logic               i_reset_n,
    mest_pro_control_if.slave  bus
);

    state_e             r_state;
    state_e             w_next_state;
    opcode_e            r_opcode;
    logic [FIELD_W-1:0] r_dst;
    logic [FIELD_W-1:0] r_srca;
    logic [FIELD_W-1:0] r_srcb;
    logic [FIELD_W-1:0] r_const_k;
    opcode_e            w_in_opcode;
    ctrl_t              w_ctrl;

    logic w_idle;
    logic w_fetch;
    logic w_exec;
    logic w_jump;
    logic w_ret;
    logic w_rf_we;
    logic w_illegal;
    logic w_done;

    assign w_in_opcode = opcode_e'(bus.i_decode_reg[OPC_LSB +: OP_CODE_SIZE]);

    mest_pro_decoder u_decoder (
        .i_opcode (r_opcode),
        .o_ctrl   (w_ctrl)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_idle       = 1'b0;
        w_fetch      = 1'b0;
        w_exec       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (bus.i_start && !bus.i_stop) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_fetch      = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC: begin
                w_exec       = 1'b1;
                w_next_state = w_ctrl.halt ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Abort wins over every sequencing decision once the program is running.
        if (r_state != ST_IDLE && bus.i_stop) w_next_state = ST_IDLE;

        w_jump    = w_exec & (w_ctrl.jump | (w_ctrl.is_jz & bus.i_zero_flag));
        w_ret     = w_exec & w_ctrl.ret;
        w_rf_we   = w_exec & w_ctrl.rf_we;
        w_illegal = w_exec & w_ctrl.illegal;
    end

    // Fetch latches the instruction at the end of FETCH, so it is stable throughout DECODE.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_opcode  <= OP_NOP;
            r_dst     <= '0;
            r_srca    <= '0;
            r_srcb    <= '0;
            r_const_k <= '0;
        end else if (r_state == ST_DECODE && !bus.i_stop) begin
            r_opcode <= w_in_opcode;
            r_dst    <= field_of(bus.i_decode_reg, DST_LSB);
            r_srca   <= field_of(bus.i_decode_reg, SRCA_LSB);
            r_srcb   <= field_of(bus.i_decode_reg, SRCB_LSB);
            if (w_in_opcode == OP_LDK) begin
                r_const_k <= field_of(bus.i_decode_reg, SRCB_LSB);
            end else if (w_in_opcode inside {OP_JMP, OP_CALL, OP_JZ}) begin
                r_const_k <= field_of(bus.i_decode_reg, DST_LSB);
            end
        end
    end

    assign bus.o_idle_state  = w_idle;
    assign bus.o_fetch_state = w_fetch;
    assign bus.o_exec_state  = w_exec;
    assign bus.o_jump        = w_jump;
    assign bus.o_return_pc   = w_ret;
    assign bus.o_const_K     = r_const_k;
    assign bus.o_alu_op      = w_ctrl.alu_op;
    assign bus.o_imm_sel     = w_ctrl.imm_sel;
    assign bus.o_rf_we       = w_rf_we;
    assign bus.o_rf_waddr    = r_dst;
    assign bus.o_rf_raddr_a  = r_srca;
    assign bus.o_rf_raddr_b  = r_srcb;
    assign bus.o_busy        = ~w_idle;
    assign bus.o_done        = w_done;
    assign bus.o_illegal     = w_illegal;
    assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_mest_pro_control.sv
// Bench for mest_pro_control: directed vector table, hand-written abort/reset/halt
// sequences and random programs checked against a per-cycle reference model.
module tb_mest_pro_control;
    import mest_pro_pkg::*;

    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_DONE   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic i_reset_n;
    always #5 clk = ~clk;

    mest_pro_control_if bus_if ();

    mest_pro_control dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .bus       (bus_if)
    );

    typedef struct packed {
        logic       idle;
        logic       fetch;
        logic       exec_s;
        logic       jump;
        logic       ret;
        logic [7:0] k;
        logic [2:0] alu;
        logic       imm_sel;
        logic       rf_we;
        logic [7:0] waddr;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       busy;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [27:0] instr;
        logic        zf;
        logic        jump;
        logic        ret;
        logic        we;
        logic        ill;
        logic        imm;
        logic [2:0]  alu;
        logic [7:0]  k;
        logic [7:0]  waddr;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        regchk;
        logic        rachk;
        logic        rbchk;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    outs_t exp_q[$];
    outs_t mask_q[$];
    logic [7:0] k_hold;
    vec_t  tbl[14];

    // ---------------- sampling / scoreboard ----------------
    function automatic outs_t sample();
        outs_t o;
        o.idle    = bus_if.o_idle_state;
        o.fetch   = bus_if.o_fetch_state;
        o.exec_s  = bus_if.o_exec_state;
        o.jump    = bus_if.o_jump;
        o.ret     = bus_if.o_return_pc;
        o.k       = bus_if.o_const_K;
        o.alu     = bus_if.o_alu_op;
        o.imm_sel = bus_if.o_imm_sel;
        o.rf_we   = bus_if.o_rf_we;
        o.waddr   = bus_if.o_rf_waddr;
        o.ra      = bus_if.o_rf_raddr_a;
        o.rb      = bus_if.o_rf_raddr_b;
        o.busy    = bus_if.o_busy;
        o.done    = bus_if.o_done;
        o.illegal = bus_if.o_illegal;
        return o;
    endfunction

    function automatic outs_t m_ctrl();
        outs_t m = '0;
        m.idle = 1'b1; m.fetch = 1'b1; m.exec_s = 1'b1; m.jump = 1'b1; m.ret = 1'b1;
        m.k = '1; m.rf_we = 1'b1; m.busy = 1'b1; m.done = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp, input outs_t m);
        n_tests++;
        if ((act & m) !== (exp & m)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, act & m, exp & m, m);
        end
    endtask

    task automatic check_sb(input string name, input outs_t act);
        outs_t e;
        outs_t m;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            check(name, act, e, m);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_phase(input int ph);
        outs_t e = '0;
        e.k = k_hold;
        case (ph)
            PH_IDLE:   e.idle = 1'b1;
            PH_FETCH:  begin e.fetch = 1'b1; e.busy = 1'b1; end
            PH_DECODE: e.busy = 1'b1;
            PH_DONE:   begin e.done = 1'b1; e.busy = 1'b1; end
            default:   e.idle = 1'b1;
        endcase
        exp_q.push_back(e);
        mask_q.push_back(m_ctrl());
    endtask

    task automatic push_exec(input logic [27:0] instr, input logic zf);
        outs_t e = '0;
        outs_t m = m_ctrl();
        logic [3:0] op;
        logic [7:0] dst, sa, sb;
        op  = instr[27:24];
        dst = instr[23:16];
        sa  = instr[15:8];
        sb  = instr[7:0];
        e.exec_s = 1'b1;
        e.busy   = 1'b1;
        if (op == 4'd6) k_hold = sb;
        else if (op == 4'd8 || op == 4'd9 || op == 4'd11) k_hold = dst;
        e.k       = k_hold;
        e.jump    = (op == 4'd8) || (op == 4'd9) || (op == 4'd11 && zf);
        e.ret     = (op == 4'd10);
        e.illegal = (op >= 4'd13);
        if (op >= 4'd1 && op <= 4'd7) begin
            e.rf_we   = 1'b1;
            e.alu     = (op <= 4'd5) ? op[2:0] : 3'd0;
            e.imm_sel = (op == 4'd6);
            e.waddr   = dst;
            m.alu = '1; m.imm_sel = 1'b1; m.waddr = '1;
        end
        if ((op >= 4'd1 && op <= 4'd5) || op == 4'd7) begin e.ra = sa; m.ra = '1; end
        if (op >= 4'd1 && op <= 4'd5) begin e.rb = sb; m.rb = '1; end
        exp_q.push_back(e);
        mask_q.push_back(m);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic start, input logic stop, input logic zf,
                         input logic [27:0] instr, output outs_t act);
        @(negedge clk);
        bus_if.i_start      = start;
        bus_if.i_stop       = stop;
        bus_if.i_zero_flag  = zf;
        bus_if.i_decode_reg = instr;
        #1 act = sample();
        @(posedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic start_prog();
        outs_t a;
        push_phase(PH_IDLE);
        drive(1'b1, 1'b0, rbit(), 28'($urandom()), a);
        check_sb("idle_start", a);
    endtask

    task automatic idle_cycle(input string name);
        outs_t a;
        push_phase(PH_IDLE);
        drive(1'b0, 1'b0, rbit(), 28'($urandom()), a);
        check_sb(name, a);
    endtask

    task automatic run_fd(input logic [27:0] instr, input logic stop_in_decode);
        outs_t a;
        push_phase(PH_FETCH);
        drive(rbit(), 1'b0, rbit(), 28'($urandom()), a);
        check_sb("fetch", a);
        push_phase(PH_DECODE);
        drive(rbit(), stop_in_decode, rbit(), instr, a);
        check_sb("decode", a);
    endtask

    task automatic run_exec(input logic [27:0] instr, input logic stop);
        outs_t a;
        logic  zf;
        zf = rbit();
        push_exec(instr, zf);
        drive(rbit(), stop, zf, 28'($urandom()), a);
        check_sb("exec", a);
    endtask

    task automatic run_halt();
        outs_t a;
        run_fd(28'hC000000, 1'b0);
        run_exec(28'hC000000, 1'b0);
        push_phase(PH_DONE);
        drive(1'b0, 1'b0, 1'b0, 28'($urandom()), a);
        check_sb("done_pulse", a);
        idle_cycle("after_done");
    endtask

    function automatic vec_t mk(logic [27:0] instr, logic zf, logic jump, logic ret,
                                logic we, logic ill, logic imm, logic [2:0] alu,
                                logic [7:0] k, logic [7:0] waddr, logic [7:0] ra,
                                logic [7:0] rb, logic regchk, logic rachk, logic rbchk);
        vec_t v;
        v.instr = instr; v.zf = zf; v.jump = jump; v.ret = ret; v.we = we; v.ill = ill;
        v.imm = imm; v.alu = alu; v.k = k; v.waddr = waddr; v.ra = ra; v.rb = rb;
        v.regchk = regchk; v.rachk = rachk; v.rbchk = rbchk;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        outs_t a;
        outs_t e;
        outs_t m;
        logic [3:0]  op;
        logic [27:0] instr;

        //           instr         zf  j  r  we il im alu  k      wa     ra     rb    reg ra rb
        tbl[0]  = mk(28'h1030102, 0, 0, 0, 1, 0, 0, 3'd1, 8'h00, 8'h03, 8'h01, 8'h02, 1, 1, 1);
        tbl[1]  = mk(28'h605007F, 0, 0, 0, 1, 0, 1, 3'd0, 8'h7F, 8'h05, 8'h00, 8'h00, 1, 0, 0);
        tbl[2]  = mk(28'h9200000, 0, 1, 0, 0, 0, 0, 3'd0, 8'h20, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[3]  = mk(28'hA000000, 1, 0, 1, 0, 0, 0, 3'd0, 8'h20, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[4]  = mk(28'hB100000, 0, 0, 0, 0, 0, 0, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[5]  = mk(28'hB100000, 1, 1, 0, 0, 0, 0, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[6]  = mk(28'h20A0B0C, 1, 0, 0, 1, 0, 0, 3'd2, 8'h10, 8'h0A, 8'h0B, 8'h0C, 1, 1, 1);
        tbl[7]  = mk(28'h3010203, 0, 0, 0, 1, 0, 0, 3'd3, 8'h10, 8'h01, 8'h02, 8'h03, 1, 1, 1);
        tbl[8]  = mk(28'h4FF8001, 0, 0, 0, 1, 0, 0, 3'd4, 8'h10, 8'hFF, 8'h80, 8'h01, 1, 1, 1);
        tbl[9]  = mk(28'h5123456, 0, 0, 0, 1, 0, 0, 3'd5, 8'h10, 8'h12, 8'h34, 8'h56, 1, 1, 1);
        tbl[10] = mk(28'h7114455, 1, 0, 0, 1, 0, 0, 3'd0, 8'h10, 8'h11, 8'h44, 8'h00, 1, 1, 0);
        tbl[11] = mk(28'hE123456, 1, 0, 0, 0, 1, 0, 3'd0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[12] = mk(28'h8330000, 0, 1, 0, 0, 0, 0, 3'd0, 8'h33, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[13] = mk(28'h0FFFFFF, 1, 0, 0, 0, 0, 0, 3'd0, 8'h33, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // Reset: IDLE, everything else zero.
        k_hold              = 8'h00;
        i_reset_n           = 1'b0;
        bus_if.i_start      = 1'b0;
        bus_if.i_stop       = 1'b0;
        bus_if.i_zero_flag  = 1'b0;
        bus_if.i_decode_reg = '0;
        #12;
        e = '0; e.idle = 1'b1;
        check("reset_state", sample(), e, '1);
        @(negedge clk);
        i_reset_n = 1'b1;

        // Directed vector table, one program, EXEC outputs checked against the table.
        start_prog();
        foreach (tbl[i]) begin
            run_fd(tbl[i].instr, 1'b0);
            drive(rbit(), 1'b0, tbl[i].zf, 28'($urandom()), a);
            e = '0; m = m_ctrl();
            e.exec_s = 1'b1; e.busy = 1'b1;
            e.jump = tbl[i].jump; e.ret = tbl[i].ret; e.rf_we = tbl[i].we;
            e.illegal = tbl[i].ill; e.k = tbl[i].k;
            if (tbl[i].regchk) begin
                e.alu = tbl[i].alu; e.imm_sel = tbl[i].imm; e.waddr = tbl[i].waddr;
                m.alu = '1; m.imm_sel = 1'b1; m.waddr = '1;
            end
            if (tbl[i].rachk) begin e.ra = tbl[i].ra; m.ra = '1; end
            if (tbl[i].rbchk) begin e.rb = tbl[i].rb; m.rb = '1; end
            check($sformatf("tbl_exec_%0d", i), a, e, m);
            k_hold = tbl[i].k;
        end
        run_halt();

        // Start and stop together in IDLE: stay IDLE.
        push_phase(PH_IDLE);
        drive(1'b1, 1'b1, 1'b0, 28'h0, a);
        check_sb("idle_start_stop", a);
        idle_cycle("idle_hold");

        // Stop during DECODE: IDLE next cycle, no done.
        start_prog();
        run_fd(28'h1030102, 1'b1);
        idle_cycle("stop_decode_idle");

        // Stop during EXEC of a JMP: EXEC outputs still driven, then IDLE.
        start_prog();
        run_fd(28'h8440000, 1'b0);
        run_exec(28'h8440000, 1'b1);
        idle_cycle("stop_exec_idle");

        // Stop during EXEC of HALT: no DONE.
        start_prog();
        run_fd(28'hC000000, 1'b0);
        run_exec(28'hC000000, 1'b1);
        idle_cycle("stop_halt_idle");

        // Asynchronous reset in the middle of an EXEC.
        start_prog();
        run_fd(28'h605005A, 1'b0);
        @(negedge clk);
        i_reset_n = 1'b0;
        #1;
        e = '0; e.idle = 1'b1;
        check("async_reset", sample(), e, '1);
        k_hold = 8'h00;
        @(negedge clk);
        i_reset_n = 1'b1;
        idle_cycle("post_reset_idle");

        // Random programs against the reference model.
        for (int p = 0; p < 6; p++) begin
            start_prog();
            for (int n = 0; n < int'($urandom_range(5, 15)); n++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hC) op = 4'h0;
                instr = {op, 24'($urandom())};
                run_fd(instr, 1'b0);
                run_exec(instr, 1'b0);
            end
            run_halt();
            idle_cycle("gap_idle");
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mest_pro_control.md
Name: mest_pro_control

Overview:
- Control and decode stage of the MEST Pro core.
- Runs the IDLE/FETCH/DECODE/EXEC/DONE sequencer. It drives the state strobes, jump, return_pc and const_K into the fetch stage, and consumes that stage's decode_reg.
- Decodes the 28-bit instruction into register-file and ALU controls for the datapath.
- Exactly one instruction is in flight; the block does not pipeline.

Parameters:
- OP_CODE_SIZE, 4, opcode width.
- FIELD_W, 8, width of each operand field.
- INSTRUCTION_SIZE, OP_CODE_SIZE+3*FIELD_W (28), instruction width.

Ports:
- clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start program; sampled in IDLE only.
- i_stop  in  1  synchronous abort to IDLE.
- i_decode_reg  in  INSTRUCTION_SIZE  instruction latched by fetch.
- i_zero_flag  in  1  registered datapath zero flag.
- o_idle_state  out  1  sequencer in IDLE.
- o_fetch_state  out  1  sequencer in FETCH.
- o_exec_state  out  1  sequencer in EXEC.
- o_jump  out  1  take branch/call this EXEC.
- o_return_pc  out  1  restore link PC this EXEC.
- o_const_K  out  FIELD_W  branch target / immediate.
- o_alu_op  out  3  0 pass, 1 add, 2 sub, 3 and, 4 or, 5 xor.
- o_imm_sel  out  1  ALU operand B = const_K.
- o_rf_we  out  1  register write enable.
- o_rf_waddr  out  FIELD_W  destination register.
- o_rf_raddr_a  out  FIELD_W  source A register.
- o_rf_raddr_b  out  FIELD_W  source B register.
- o_busy  out  1  not IDLE.
- o_done  out  1  one-cycle pulse on HALT completion.
- o_illegal  out  1  one-cycle pulse on reserved opcode.

Behaviour:
- Instruction format:
  - [27:24] opcode.
  - [23:16] dst/K.
  - [15:8] srcA.
  - [7:0] srcB/imm.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDK, 7 MOV, 8 JMP, 9 CALL, A RET, B JZ, C HALT, D-F reserved.
- State encoding:
  - One-hot strobes derived from a registered state.
  - State strobes are Moore outputs.
  - Reset state is IDLE: o_idle_state=1, o_busy=0, all other outputs 0.
- Transitions:
  - IDLE -> FETCH on i_start.
  - FETCH -> DECODE.
  - DECODE -> EXEC.
  - EXEC -> FETCH, or EXEC -> DONE if the opcode is HALT.
  - DONE -> IDLE.
  - Steady loop is 3 cycles per instruction.
- DECODE: register the opcode and fields from i_decode_reg. The instruction is valid here because fetch latches at the end of FETCH. All decoded outputs are driven from these registers.
- EXEC is the only state where o_jump, o_return_pc and o_rf_we can be 1; they are 0 elsewhere.
- Per-opcode actions in EXEC:
  - ALU ops (1-5): rf_we=1, waddr=dst, raddr_a=srcA, raddr_b=srcB, imm_sel=0.
  - LDK: rf_we=1, alu_op=pass, imm_sel=1, o_const_K=imm[7:0].
  - MOV: rf_we=1, alu_op=pass, raddr_a=srcA, imm_sel=0.
  - JMP and CALL: o_jump=1, o_const_K=field[23:16]. Fetch always saves the link on jump, so JMP and CALL are identical at this interface.
  - JZ: o_jump=i_zero_flag, sampled in the EXEC cycle.
  - RET: o_return_pc=1.
  - HALT: no writes; o_done=1 during DONE.
  - Reserved opcodes: behave as NOP; o_illegal=1 for the EXEC cycle; execution continues.
- o_jump and o_return_pc are never both 1.
- o_const_K holds its last decoded value outside EXEC.
- i_stop:
  - Highest priority in every state except IDLE.
  - Next state is IDLE; no o_done.
  - An EXEC coinciding with i_stop still drives its EXEC outputs that cycle.
- i_start while busy is ignored. i_start and i_stop both high in IDLE: stay IDLE.
- Reset asserted mid-operation: immediately IDLE and all outputs 0. Decode registers clear to 0 (NOP).

Decomposition:
- Shared package mest_pro_pkg holds:
  - the opcode enum (4 bits);
  - the state enum;
  - the alu_op enum (3 bits);
  - field bit-position constants;
  - a control-bundle struct {alu_op, imm_sel, rf_we, jump, is_jz, ret, halt, illegal}.
- Sub-module mest_pro_decoder: purely combinational, opcode -> control bundle.
- mest_pro_control keeps the FSM, decode registers and EXEC gating.

Test Plan:
- Reset then i_start pulse → o_fetch_state=1 at cycle 1, DECODE at cycle 2, o_exec_state=1 at cycle 3; back to FETCH at cycle 4.
- Decode 0x1_03_01_02 (ADD) → in EXEC: rf_we=1, waddr=3, raddr_a=1, raddr_b=2, alu_op=1, imm_sel=0.
- Decode 0x6_05_00_7F (LDK) → in EXEC: rf_we=1, waddr=5, imm_sel=1, o_const_K=0x7F.
- Decode 0x9_20_00_00 (CALL), then later 0xA_00_00_00 (RET) → o_jump=1 with o_const_K=0x20 in the first EXEC; o_return_pc=1 in the second EXEC.
- Decode JZ 0xB_10_00_00 with i_zero_flag=0 → o_jump=0; repeat with i_zero_flag=1 → o_jump=1, o_const_K=0x10.
- Decode HALT (0xC_00_00_00) → o_done pulses for 1 cycle, then o_idle_state=1. Opcode 0xE → o_illegal pulses for 1 cycle and FETCH follows. i_stop in DECODE → IDLE next cycle, o_done=0.
